// File: rtl/dsp48a1_seq.sv
// Sequencer driving one DSP48A1 (A1/B1/C/D/M/P/OPMODE/CARRYIN registered) from a valid/ready request stream.
// Optional completed-operation counter on op_count is enabled by defining DSP_SEQ_OPCOUNT_EN.
module dsp48a1_seq (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [17:0] req_a,
  input  logic [17:0] req_b,
  input  logic [17:0] req_d,
  input  logic [47:0] req_c,
  input  logic [7:0]  req_opmode,
  input  logic        req_carryin,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [47:0] rsp_p,
  output logic        rsp_carryout,
  output logic [17:0] DSP_A,
  output logic [17:0] DSP_B,
  output logic [17:0] DSP_D,
  output logic [47:0] DSP_C,
  output logic [7:0]  DSP_OPMODE,
  output logic        DSP_CARRYIN,
  output logic        DSP_CEA,
  output logic        DSP_CEB,
  output logic        DSP_CEC,
  output logic        DSP_CED,
  output logic        DSP_CEM,
  output logic        DSP_CEP,
  output logic        DSP_CECARRYIN,
  output logic        DSP_CEOPMODE,
  output logic        DSP_RST,
  input  logic [47:0] DSP_P,
`ifdef DSP_SEQ_OPCOUNT_EN
  output logic [15:0] op_count,
`endif
  input  logic        DSP_CARRYOUT
);

  localparam int unsigned DW   = 18;
  localparam int unsigned CW   = 48;
  localparam int unsigned OW   = 8;
  localparam int unsigned CNTW = 16;

  typedef enum logic [2:0] {IDLE, S_CD, S_AB, S_M, S_P, S_CAP, RESP} state_t;

  state_t state;

  // Each state's clock enables are registered on entry, so they are high exactly while in that state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_p         <= CW'(0);
      rsp_carryout  <= 1'b0;
      DSP_A         <= DW'(0);
      DSP_B         <= DW'(0);
      DSP_D         <= DW'(0);
      DSP_C         <= CW'(0);
      DSP_OPMODE    <= OW'(0);
      DSP_CARRYIN   <= 1'b0;
      DSP_CEA       <= 1'b0;
      DSP_CEB       <= 1'b0;
      DSP_CEC       <= 1'b0;
      DSP_CED       <= 1'b0;
      DSP_CEM       <= 1'b0;
      DSP_CEP       <= 1'b0;
      DSP_CECARRYIN <= 1'b0;
      DSP_CEOPMODE  <= 1'b0;
      DSP_RST       <= 1'b1;
`ifdef DSP_SEQ_OPCOUNT_EN
      op_count      <= CNTW'(0);
`endif
    end else begin
      DSP_RST       <= 1'b0;
      DSP_CEA       <= 1'b0;
      DSP_CEB       <= 1'b0;
      DSP_CEC       <= 1'b0;
      DSP_CED       <= 1'b0;
      DSP_CEM       <= 1'b0;
      DSP_CEP       <= 1'b0;
      DSP_CECARRYIN <= 1'b0;
      DSP_CEOPMODE  <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            DSP_A         <= req_a;
            DSP_B         <= req_b;
            DSP_D         <= req_d;
            DSP_C         <= req_c;
            DSP_OPMODE    <= req_opmode;
            DSP_CARRYIN   <= req_carryin;
            DSP_CEC       <= 1'b1;
            DSP_CED       <= 1'b1;
            DSP_CECARRYIN <= 1'b1;
            DSP_CEOPMODE  <= 1'b1;
            req_ready     <= 1'b0;
            state         <= S_CD;
          end else begin
            // Held low for one cycle after DSP_RST drops so the DSP leaves reset first.
            req_ready <= !DSP_RST;
          end
        end
        S_CD: begin
          DSP_CEA <= 1'b1;
          DSP_CEB <= 1'b1;
          state   <= S_AB;
        end
        S_AB: begin
          DSP_CEM <= 1'b1;
          state   <= S_M;
        end
        S_M: begin
          DSP_CEP <= 1'b1;
          state   <= S_P;
        end
        S_P: begin
          state <= S_CAP;
        end
        S_CAP: begin
          rsp_p        <= DSP_P;
          rsp_carryout <= DSP_CARRYOUT;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
`ifdef DSP_SEQ_OPCOUNT_EN
            op_count  <= op_count + CNTW'(1);
`endif
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp48a1_seq.sv
// Directed bench for dsp48a1_seq with a behavioural DSP48A1 (A1/B1/C/D/M/P/OPMODE registered, sync reset).
module tb_dsp48a1_seq;

  logic        CLK;
  logic        RST_N;
  logic        req_valid, req_ready;
  logic [17:0] req_a, req_b, req_d;
  logic [47:0] req_c;
  logic [7:0]  req_opmode;
  logic        req_carryin;
  logic        rsp_valid, rsp_ready;
  logic [47:0] rsp_p;
  logic        rsp_carryout;
  logic [17:0] DSP_A, DSP_B, DSP_D;
  logic [47:0] DSP_C;
  logic [7:0]  DSP_OPMODE;
  logic        DSP_CARRYIN;
  logic        DSP_CEA, DSP_CEB, DSP_CEC, DSP_CED, DSP_CEM, DSP_CEP, DSP_CECARRYIN, DSP_CEOPMODE;
  logic        DSP_RST;
  logic [47:0] DSP_P;
  logic        DSP_CARRYOUT;
`ifdef DSP_SEQ_OPCOUNT_EN
  logic [15:0] op_count;
`endif

  int checks = 0;
  int errors = 0;

  dsp48a1_seq dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_d(req_d), .req_c(req_c),
    .req_opmode(req_opmode), .req_carryin(req_carryin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .rsp_carryout(rsp_carryout),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_D(DSP_D), .DSP_C(DSP_C),
    .DSP_OPMODE(DSP_OPMODE), .DSP_CARRYIN(DSP_CARRYIN),
    .DSP_CEA(DSP_CEA), .DSP_CEB(DSP_CEB), .DSP_CEC(DSP_CEC), .DSP_CED(DSP_CED),
    .DSP_CEM(DSP_CEM), .DSP_CEP(DSP_CEP), .DSP_CECARRYIN(DSP_CECARRYIN),
    .DSP_CEOPMODE(DSP_CEOPMODE), .DSP_RST(DSP_RST),
    .DSP_P(DSP_P),
`ifdef DSP_SEQ_OPCOUNT_EN
    .op_count(op_count),
`endif
    .DSP_CARRYOUT(DSP_CARRYOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural DSP48A1 slice in the target register configuration
  logic [17:0] a1_r, b1_r, d_r;
  logic [47:0] c_r;
  logic [7:0]  op_r;
  logic        cin_r;
  logic [35:0] m_r;
  logic [47:0] x_v, z_v;
  logic [48:0] post_v;

  always_comb begin
    x_v = 48'd0;
    z_v = 48'd0;
    case (op_r[1:0])
      2'b01: x_v = {{12{m_r[35]}}, m_r};
      2'b10: x_v = DSP_P;
      2'b11: x_v = {d_r[11:0], a1_r, b1_r};
      default: x_v = 48'd0;
    endcase
    case (op_r[3:2])
      2'b10: z_v = DSP_P;
      2'b11: z_v = c_r;
      default: z_v = 48'd0;
    endcase
    if (op_r[7]) post_v = {1'b0, z_v} - ({1'b0, x_v} + 49'(cin_r));
    else         post_v = {1'b0, z_v} + {1'b0, x_v} + 49'(cin_r);
  end

  always @(posedge CLK) begin
    if (DSP_RST) begin
      a1_r <= '0; b1_r <= '0; d_r <= '0; c_r <= '0; op_r <= '0; cin_r <= 1'b0;
      m_r <= '0; DSP_P <= '0; DSP_CARRYOUT <= 1'b0;
    end else begin
      if (DSP_CEC) c_r <= DSP_C;
      if (DSP_CED) d_r <= DSP_D;
      if (DSP_CEOPMODE) op_r <= DSP_OPMODE;
      if (DSP_CECARRYIN) cin_r <= DSP_OPMODE[5];
      if (DSP_CEA) a1_r <= DSP_A;
      if (DSP_CEB) b1_r <= op_r[4] ? (op_r[6] ? d_r - DSP_B : d_r + DSP_B) : DSP_B;
      if (DSP_CEM) m_r <= 36'($signed(a1_r) * $signed(b1_r));
      if (DSP_CEP) begin
        DSP_P <= post_v[47:0];
        DSP_CARRYOUT <= post_v[48];
      end
    end
  end

  function automatic logic [7:0] ce_vec();
    return {DSP_CEA, DSP_CEB, DSP_CEC, DSP_CED, DSP_CEM, DSP_CEP, DSP_CECARRYIN, DSP_CEOPMODE};
  endfunction

  localparam logic [7:0] CE_CD = 8'b0011_0011;
  localparam logic [7:0] CE_AB = 8'b1100_0000;
  localparam logic [7:0] CE_M  = 8'b0000_1000;
  localparam logic [7:0] CE_P  = 8'b0000_0100;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_req(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                           input logic [47:0] c, input logic [7:0] op);
    req_valid = 1'b1; req_a = a; req_b = b; req_d = d; req_c = c; req_opmode = op; req_carryin = 1'b0;
  endtask

  // Drives one request through to its response handshake; timeouts count as failures.
  task automatic run_op(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                        input logic [47:0] c, input logic [7:0] op, output logic [47:0] p);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL run_op_accept: req_ready=%b required 1 within 20 cycles", req_ready); end
    drive_req(a, b, d, c, op);
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    checks++;
    if (!rsp_valid) begin errors++; $display("FAIL run_op_rsp: rsp_valid=%b required 1 within 20 cycles", rsp_valid); end
    p = rsp_p;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) step();
    checks++;
    if (DSP_RST !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_p !== 48'd0 ||
        rsp_carryout !== 1'b0 || ce_vec() !== 8'd0 || DSP_A !== 18'd0 || DSP_C !== 48'd0 || DSP_OPMODE !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: rst=%b rdy=%b vld=%b p=%0d ce=%b a=%0d required rst=1 others 0",
               DSP_RST, req_ready, rsp_valid, rsp_p, ce_vec(), DSP_A);
    end
`ifdef DSP_SEQ_OPCOUNT_EN
    checks++;
    if (op_count !== 16'd0) begin errors++; $display("FAIL reset_opcount: op_count=%0d required 0", op_count); end
`endif
    RST_N = 1'b1;
    #1;
    checks++;
    if (DSP_RST !== 1'b1) begin errors++; $display("FAIL reset_release_hold: DSP_RST=%b required 1", DSP_RST); end
    step();
    checks++;
    if (DSP_RST !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_first_edge: DSP_RST=%b req_ready=%b required 0 0", DSP_RST, req_ready);
    end
    step();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ready: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_multiply();
    logic [7:0] exp_ce [5];
    exp_ce[0] = CE_CD; exp_ce[1] = CE_AB; exp_ce[2] = CE_M; exp_ce[3] = CE_P; exp_ce[4] = 8'd0;
    drive_req(18'd3, 18'd5, 18'd0, 48'd0, 8'h01);
    for (int i = 0; i < 5; i++) begin
      step();
      req_valid = 1'b0;
      checks++;
      if (ce_vec() !== exp_ce[i] || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL mul_ce_cycle%0d: ce=%b vld=%b rdy=%b required ce=%b vld=0 rdy=0",
                 i, ce_vec(), rsp_valid, req_ready, exp_ce[i]);
      end
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 48'd15 || ce_vec() !== 8'd0) begin
      errors++; $display("FAIL mul_result: vld=%b p=%0d ce=%b required vld=1 p=15 ce=0", rsp_valid, rsp_p, ce_vec());
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL mul_handshake: vld=%b rdy=%b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_mac();
    logic [47:0] p;
    run_op(18'd4, 18'd6, 18'd0, 48'd10, 8'h0D, p);
    checks++;
    if (p !== 48'd34) begin errors++; $display("FAIL mac_result: p=%0d required 34", p); end
  endtask

  task automatic test_preadd();
    logic [47:0] p;
    run_op(18'd3, 18'd2, 18'd7, 48'd0, 8'h11, p);
    checks++;
    if (p !== 48'd27) begin errors++; $display("FAIL preadd_result: p=%0d required 27", p); end
  endtask

  task automatic test_back_to_back();
    int n;
    drive_req(18'd3, 18'd5, 18'd0, 48'd0, 8'h01);
    step();
    drive_req(18'd4, 18'd4, 18'd0, 48'd0, 8'h01);
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 48'd15) begin
      errors++; $display("FAIL bp_first: vld=%b p=%0d required 1 15", rsp_valid, rsp_p);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_p !== 48'd15 || req_ready !== 1'b0 || DSP_A !== 18'd3 || ce_vec() !== 8'd0) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b p=%0d rdy=%b a=%0d ce=%b required 1 15 0 3 0",
                 i, rsp_valid, rsp_p, req_ready, DSP_A, ce_vec());
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || DSP_A !== 18'd3) begin
      errors++; $display("FAIL bp_release: vld=%b rdy=%b a=%0d required 0 1 3", rsp_valid, req_ready, DSP_A);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (DSP_A !== 18'd4 || ce_vec() !== CE_CD || req_ready !== 1'b0) begin
      errors++; $display("FAIL bp_second_accept: a=%0d ce=%b rdy=%b required 4 %b 0", DSP_A, ce_vec(), req_ready, CE_CD);
    end
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 48'd16) begin
      errors++; $display("FAIL bp_second_result: vld=%b p=%0d required 1 16", rsp_valid, rsp_p);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [47:0] p;
    drive_req(18'd5, 18'd5, 18'd0, 48'd0, 8'h01);
    step();
    req_valid = 1'b0;
    step();
    step();
    checks++;
    if (ce_vec() !== CE_M) begin errors++; $display("FAIL midop_in_m: ce=%b required %b", ce_vec(), CE_M); end
    RST_N = 1'b0;
    #1;
    checks++;
    if (ce_vec() !== 8'd0 || DSP_RST !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_async: ce=%b rst=%b vld=%b rdy=%b required 0 1 0 0", ce_vec(), DSP_RST, rsp_valid, req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b0 || ce_vec() !== 8'd0) begin
        errors++; $display("FAIL midop_hold%0d: vld=%b ce=%b required 0 0", i, rsp_valid, ce_vec());
      end
    end
    RST_N = 1'b1;
    step();
    step();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_p !== 48'd0) begin
      errors++; $display("FAIL midop_rerelease: rdy=%b vld=%b p=%0d required 1 0 0", req_ready, rsp_valid, rsp_p);
    end
    run_op(18'd2, 18'd2, 18'd0, 48'd0, 8'h01, p);
    checks++;
    if (p !== 48'd4) begin errors++; $display("FAIL midop_fresh: p=%0d required 4", p); end
`ifdef DSP_SEQ_OPCOUNT_EN
    checks++;
    if (op_count !== 16'd1) begin errors++; $display("FAIL midop_opcount: op_count=%0d required 1", op_count); end
`endif
  endtask

  initial begin
    RST_N = 1'b0;
    req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_d = '0; req_c = '0; req_opmode = '0; req_carryin = 1'b0;
    #2;
    test_reset();
    test_multiply();
    test_mac();
    test_preadd();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
